dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single data memory (DATA_MEM_DEPTH words) between SUBCORE_NUM subcores.
//  Accepts at most one load/store per cycle and drives the memory port.
//  Returns each load's data to its issuing subcore a fixed MEM_LATENCY cycles after grant.
//  Sits between the subcore load/store stages and the data memory instance.
// PARAMETERS
//  NREQ         SUBCORE_NUM (4)       number of requesters
//  DEPTH        DATA_MEM_DEPTH (131072) memory words; ADDR_W = $clog2(DEPTH) = 17
//  MEM_LATENCY  2                     cycles from mem_en to valid mem_dout (range 1..4)
// PORTS
//  clk          in   1          system clock
//  rstn         in   1          asynchronous active-low reset
//  req_valid    in   NREQ       per-subcore request pending
//  req_addr     in   NREQ*32    word address, requester i in bits [32*i+31:32*i]
//  req_din      in   NREQ*32    store data, same packing
//  req_we       in   NREQ       1 = store, 0 = load
//  req_ready    out  NREQ       one-hot grant; request i accepted when req_valid[i] & req_ready[i]
//  mem_en       out  1          memory access strobe
//  mem_we       out  1          memory write enable
//  mem_addr     out  ADDR_W     memory word address
//  mem_din      out  32         memory write data
//  mem_dout     in   32         memory read data, valid MEM_LATENCY cycles after mem_en
//  resp_valid   out  NREQ       one-hot, load data valid for requester i
//  resp_data    out  32         load data, shared by all requesters
//  addr_err     out  1          sticky: some accepted request had addr >= DEPTH
// BEHAVIOUR
//  Reset (rstn=0, async): all outputs 0; rr_ptr=0; in-flight pipeline cleared.
//   Outstanding loads are dropped, with no response after reset release.
//  Arbitration: combinational; req_ready is one-hot or zero.
//   Grant the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//   On grant of i, rr_ptr <= (i+1) mod NREQ; no grant -> rr_ptr holds.
//   req_ready[i] is never 1 while req_valid[i]=0.
//  Handshake:
//   - Requester holds valid/addr/din/we stable until accepted.
//   - Arbiter takes no bubbles: back-to-back grants every cycle while any request is pending.
//  Memory port:
//   - Registered; the cycle after acceptance, mem_en=1, mem_we=req_we, mem_addr=req_addr[ADDR_W-1:0], mem_din=req_din.
//   - Otherwise mem_en=0, mem_we=0, and addr/din hold their last value.
//   - mem_we is never 1 while mem_en=0.
//  Load return:
//   - Each cycle, push {load_valid, id} into a MEM_LATENCY-deep shift register alongside mem_en.
//   - Pop registers resp_valid[id] and resp_data=mem_dout.
//   - Load accepted at cycle T: resp_valid one-hot at T+1+MEM_LATENCY (+1 output register).
//   - Total load latency is MEM_LATENCY+2 cycles from acceptance.
//   - Responses return in acceptance order; pipelined loads give one response per cycle.
//   - Stores produce no response.
//   - resp_data holds its value when resp_valid=0.
//  Address range:
//   - addr[31:ADDR_W]!=0 on accepted request: access still issued with truncated address, addr_err set.
//   - addr_err clears only on reset.
//  Same-address store then load (any requesters): memory order = grant order, so the load sees the new data.
//  Fairness: a continuously asserted req_valid[i] is granted within NREQ cycles.
// TESTING
//  - Reset: rstn low mid-burst with 2 loads in flight -> all outputs 0, no resp_valid after release.
//  - Single load: core 2 load addr 0x10 (mem[0x10]=0xDEADBEEF) at T -> mem_en T+1, resp_valid=4'b0100, data 0xDEADBEEF at T+4.
//  - All 4 valid continuously from rr_ptr=0 -> grants 0,1,2,3,0,1... one per cycle, no idle cycle.
//  - Core 1 stores 0x1234 to 0x100, core 3 loads 0x100 the next cycle -> core 3 gets 0x00001234.
//  - Core 0 load addr 0x00020005 -> mem_addr=0x00005, addr_err=1 sticky until reset.
//  - Random traffic, 10k cycles vs. reference model -> ordered data match; each requester starves <= 4 cycles.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data memory among NREQ subcores
// Ports: clk, rstn (async active-low); req_valid/req_addr/req_din/req_we per-subcore requests,
//        req_ready one-hot grant; mem_en/mem_we/mem_addr/mem_din registered memory port, mem_dout read data;
//        resp_valid/resp_data load return MEM_LATENCY+2 cycles after grant; addr_err sticky range error.
module dmem_arbiter #(
    parameter int NREQ         = 4,
    parameter int DEPTH        = 131072,
    parameter int MEM_LATENCY  = 2,
    localparam int ADDR_W      = $clog2(DEPTH),
    localparam int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*32-1:0]  req_addr,
    input  logic [NREQ*32-1:0]  req_din,
    input  logic [NREQ-1:0]     req_we,
    output logic [NREQ-1:0]     req_ready,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_din,
    input  logic [31:0]         mem_dout,
    output logic [NREQ-1:0]     resp_valid,
    output logic [31:0]         resp_data,
    output logic                addr_err
);
    logic [IDW-1:0] rr_ptr, gnt_id, ld_id;
    logic gnt, ld_v;
    logic [31:0] gnt_addr;
    logic [MEM_LATENCY-1:0] pv;
    logic [MEM_LATENCY-1:0][IDW-1:0] pid;

    // scan downwards so the candidate closest to rr_ptr is the one that sticks
    always_comb begin
        gnt = 1'b0;
        gnt_id = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                gnt = 1'b1;
                gnt_id = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign req_ready = gnt ? NREQ'(1) << gnt_id : '0;
    assign gnt_addr = req_addr[32*gnt_id +: 32];

    // ld_v/ld_id travel with mem_en; pv/pid then delay them until mem_dout is valid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_din <= '0;
            addr_err <= 1'b0;
            ld_v <= 1'b0;
            ld_id <= '0;
            pv <= '0;
            pid <= '0;
            resp_valid <= '0;
            resp_data <= '0;
        end else begin
            mem_en <= gnt;
            mem_we <= gnt & req_we[gnt_id];
            ld_v <= gnt & ~req_we[gnt_id];
            ld_id <= gnt_id;
            if (gnt) begin
                rr_ptr <= IDW'((int'(gnt_id) + 1) % NREQ);
                mem_addr <= gnt_addr[ADDR_W-1:0];
                mem_din <= req_din[32*gnt_id +: 32];
                addr_err <= addr_err | (|gnt_addr[31:ADDR_W]);
            end
            pv[0] <= ld_v;
            pid[0] <= ld_id;
            for (int k = 1; k < MEM_LATENCY; k++) begin
                pv[k] <= pv[k-1];
                pid[k] <= pid[k-1];
            end
            resp_valid <= pv[MEM_LATENCY-1] ? NREQ'(1) << pid[MEM_LATENCY-1] : '0;
            if (pv[MEM_LATENCY-1])
                resp_data <= mem_dout;
        end
    end
endmodule
